qdiv: RTL and testbench

QDIV -- requirements
Module: qdiv

---
 rtl/qdiv.sv | 159 +++++++++++++++
 tb/tb_qdiv.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/qdiv.sv
// qdiv: sequential sign-magnitude fixed-point divider.
//
// Operands and result are N-bit sign-magnitude words. Bit N-1 is the sign and
// bits N-2:0 are an unsigned magnitude with Q fractional bits. The quotient
// magnitude is floor((|a| << Q) / |b|). It is computed by restoring
// shift-subtract, one bit per clock, MSB first.
//
// Ports
//   clk    : clock; all state updates on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : request a divide; accepted only when busy is low
//   a, b   : dividend / divisor (sign-magnitude, Q fractional bits)
//   busy   : high while a division is in progress
//   done   : one-cycle pulse; q/ovf/dbz are valid from this cycle on
//   q      : quotient (sign-magnitude, Q fractional bits)
//   ovf    : quotient magnitude overflowed and was saturated
//   dbz    : divisor magnitude was zero
module qdiv #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic         ovf,
  output logic         dbz
);

  localparam int unsigned M  = N - 1;          // magnitude width
  localparam int unsigned W  = N - 1 + Q;      // internal dividend / quotient width
  localparam int unsigned CW = $clog2(W + 1);  // iteration counter width

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [W-1:0]   dq_q,    dq_d;     // dividend shifting out, quotient shifting in
  logic [M-1:0]   rem_q,   rem_d;    // partial remainder, always < divisor
  logic [M-1:0]   div_q,   div_d;    // latched divisor magnitude
  logic           sign_q,  sign_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;
  logic [N-1:0]   res_q,   res_d;
  logic           ovf_q,   ovf_d;
  logic           dbz_q,   dbz_d;

  logic [N-1:0]   rem_shift;
  logic           rem_ge;
  logic [M-1:0]   mag;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_q, dq_q[W-1]};
  assign rem_ge    = rem_shift >= {1'b0, div_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    div_d   = div_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    mag     = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Operands are captured here; a and b are free to change afterwards.
          state_d = DIV;
          cnt_d   = '0;
          dq_d    = W'(a[M-1:0]) << Q;
          rem_d   = '0;
          div_d   = b[M-1:0];
          sign_d  = a[N-1] ^ b[N-1];
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      DIV: begin
        if (div_q == '0) begin
          // Zero divisor: leave after one cycle with a saturated result.
          state_d = DONE;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
          res_d   = {sign_q, {M{1'b1}}};
        end else if (cnt_q == CW'(W)) begin
          // All quotient bits are in dq_q; saturate if it exceeds M bits.
          state_d = DONE;
          done_d  = 1'b1;
          if (|dq_q[W-1:M]) begin
            ovf_d = 1'b1;
            mag   = '1;
          end else begin
            mag   = dq_q[M-1:0];
          end
          res_d = {sign_q & (mag != '0), mag};
        end else begin
          cnt_d = cnt_q + 1'b1;
          dq_d  = {dq_q[W-2:0], rem_ge};
          rem_d = rem_ge ? M'(rem_shift - {1'b0, div_q}) : rem_shift[M-1:0];
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DIV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = res_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_qdiv.sv
// tb_qdiv: directed-vector bench for qdiv (N=32, Q=15) with hand-computed
// expected quotients, flags and done latencies.
module tb_qdiv;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic        ovf;
  logic        dbz;

  qdiv #(.N(32), .Q(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] last_q  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the budget runs out; n counts edges taken.
  task automatic wait_done(input int start_n, input int limit, output int n);
    n = start_n;
    while (!done && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_q, input logic exp_ovf, input logic exp_dbz,
                        input int exp_lat);
    int n;
    a = av;
    b = bv;
    start = 1'b1;
    tick();                       // accepting edge
    start = 1'b0;
    a = $urandom;                 // operands must already be latched
    b = $urandom;
    check({tag, "/busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, "/flags_cleared"}, {30'd0, ovf, dbz}, 32'd0);
    check({tag, "/q_held"}, q, last_q);
    wait_done(0, 100, n);
    check({tag, "/latency"}, 32'(n), 32'(exp_lat));
    check({tag, "/q"}, q, exp_q);
    check({tag, "/ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "/dbz"}, 32'(dbz), 32'(exp_dbz));
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, "/done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "/q_hold_after"}, q, exp_q);
    check({tag, "/ovf_hold_after"}, 32'(ovf), 32'(exp_ovf));
    last_q = exp_q;
  endtask

  initial begin
    int n;
    int pulses;

    // Reset state
    tick();
    tick();
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/q",    q,         32'd0);
    check("reset/ovf",  32'(ovf),  32'd0);
    check("reset/dbz",  32'(dbz),  32'd0);
    rst_n = 1'b1;
    tick();

    // Main function
    run_op("basic",    32'h0000C000, 32'h00004000, 32'h00018000, 1'b0, 1'b0, 47);
    run_op("neg",      32'h8000C000, 32'h00004000, 32'h80018000, 1'b0, 1'b0, 47);
    run_op("third",    32'h00008000, 32'h00018000, 32'h00002AAA, 1'b0, 1'b0, 47);
    run_op("dbz_neg",  32'h80008000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1);
    run_op("dbz_pos",  32'h80008000, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1);
    run_op("ovf",      32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 47);
    run_op("negzero",  32'h00000000, 32'h80004000, 32'h00000000, 1'b0, 1'b0, 47);

    // start held high: second op accepted in the DONE cycle
    a = 32'h0000C000;
    b = 32'h00004000;
    start = 1'b1;
    tick();
    wait_done(0, 100, n);
    check("b2b/first_latency", 32'(n), 32'd47);
    check("b2b/first_q", q, 32'h00018000);
    a = 32'h00008000;
    b = 32'h00018000;
    tick();                       // accepted in DONE
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check("b2b/done_dropped", 32'(done), 32'd0);
    check("b2b/busy_again", 32'(busy), 32'd1);
    wait_done(1, 100, n);
    check("b2b/done_spacing", 32'(n), 32'd48);
    check("b2b/second_q", q, 32'h00002AAA);
    tick();

    // start pulse mid-DIV is ignored
    a = 32'h0000C000;
    b = 32'h00004000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    a = 32'h7FFFFFFF;
    b = 32'h00000001;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(11, 100, n);
    check("mid_start/latency", 32'(n), 32'd47);
    check("mid_start/q", q, 32'h00018000);
    check("mid_start/ovf", 32'(ovf), 32'd0);
    tick();

    // Reset during iteration 20 aborts without a done pulse
    a = 32'h7FFFFFFF;
    b = 32'h00000001;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/q",    q,         32'd0);
    check("abort/ovf",  32'(ovf),  32'd0);
    check("abort/dbz",  32'(dbz),  32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) pulses++;
    end
    check("abort/no_done", 32'(pulses), 32'd0);
    last_q = '0;

    // Reset wins over start on the same edge
    a = 32'h0000C000;
    b = 32'h00004000;
    start = 1'b1;
    rst_n = 1'b0;
    tick();
    check("rst_prio/busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_prio/idle", 32'(busy), 32'd0);

    run_op("recover",  32'h0000C000, 32'h00004000, 32'h00018000, 1'b0, 1'b0, 47);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
